// File: rtl/itiming.sv
// ---------------------------------------------------------------------------
// itiming -- instruction register and cycle-timing sequencer.
//
// Sits directly upstream of instdecode. It latches each opcode from the data
// bus on a fetch edge and steps the 3-bit cycle counter from the decoder's
// icyc/scyc/rcyc strobes. It also synchronises irqin/nmiin, holds the
// reset/NMI requests, and injects INT_OPCODE in place of the fetched opcode
// so the decoder runs its interrupt sequence.
//
// Optional feature (compile-time macro ILLEGAL_TRAP_EN):
//   defined   : an edge with rdy=1 and no strobe forces inst<=NOP_OPCODE,
//               cycle<=1 and pulses illegal for one clock
//   undefined : no strobe simply holds inst/cycle; illegal is tied 0
//
// Ports:
//   clk      in   system clock, all state on rising edge
//   clr      in   asynchronous active-high reset
//   rdy      in   1 = advance; 0 = freeze inst/cycle/fetchpend
//   databus  in   opcode source during a fetch in cycle 0
//   irqin    in   external IRQ level, asynchronous
//   nmiin    in   external NMI, rising-edge, asynchronous
//   irqdis   in   status I flag, masks irqreq
//   icyc     in   cycle <= cycle+1 (saturating)
//   scyc     in   cycle <= cycle+2 (saturating)
//   rcyc     in   cycle <= 0 and arm an opcode fetch
//   sinst    in   interrupt service started: clear top pending request
//   inst     out  instruction register
//   cycle    out  cycle within the instruction
//   resreq   out  reset request pending
//   nmireq   out  NMI request pending
//   irqreq   out  synchronised irqin & ~irqdis
//   illegal  out  one-clock trap pulse (0 unless ILLEGAL_TRAP_EN)
// ---------------------------------------------------------------------------
module itiming #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  INT_OPCODE  = 8'h00,
    parameter logic [7:0]  NOP_OPCODE  = 8'hea
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rdy,
    input  logic [7:0] databus,
    input  logic       irqin,
    input  logic       nmiin,
    input  logic       irqdis,
    input  logic       icyc,
    input  logic       scyc,
    input  logic       rcyc,
    input  logic       sinst,
    output logic [7:0] inst,
    output logic [2:0] cycle,
    output logic       resreq,
    output logic       nmireq,
    output logic       irqreq,
    output logic       illegal
);

    logic [SYNC_STAGES-1:0] irq_sync;
    logic [SYNC_STAGES-1:0] nmi_sync;
    logic                   nmi_prev;
    logic                   fetchpend;

    logic       anystrobe;
    logic       fetch;
    logic       inject;
    logic       trap;
    logic       nmi_rise;
    logic       clr_res;
    logic       clr_nmi;
    logic [3:0] sum;
    logic [2:0] cyc_step;
    logic [7:0] inst_n;
    logic [2:0] cycle_n;
    logic       fp_n;

    // ---------------- synchronisers ----------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            irq_sync <= '0;
            nmi_sync <= '0;
            nmi_prev <= 1'b0;
        end else begin
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], irqin};
            nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmiin};
            nmi_prev <= nmi_sync[SYNC_STAGES-1];
        end
    end

    assign irqreq   = irq_sync[SYNC_STAGES-1] & ~irqdis;
    assign nmi_rise = nmi_sync[SYNC_STAGES-1] & ~nmi_prev;

    // sinst is a decoder strobe, so it only acts on an advancing edge.
    // It retires resreq first; nmireq only once no reset is pending.
    assign clr_res = rdy & sinst;
    assign clr_nmi = rdy & sinst & ~resreq;

    // ---------------- cycle / instruction sequencing ----------------
    assign anystrobe = icyc | scyc | rcyc;
    assign fetch     = (cycle == 3'd0) & fetchpend;
    // A pending request replaces the fetched opcode; the bus byte is dropped
    // and refetched after service because PC has not moved yet.
    assign inject    = fetch & (resreq | nmireq | irqreq);

`ifdef ILLEGAL_TRAP_EN
    assign trap = rdy & ~anystrobe & ~inject;
`else
    assign trap = 1'b0;
`endif

    // Saturating step: 7+2 fits in 4 bits, so bit 3 flags overflow.
    always_comb begin
        sum = {1'b0, cycle} + (scyc ? 4'd2 : 4'd1);
        if (rcyc)
            cyc_step = 3'd0;
        else if (scyc | icyc)
            cyc_step = sum[3] ? 3'd7 : sum[2:0];
        else
            cyc_step = cycle;
    end

    always_comb begin
        inst_n  = inst;
        cycle_n = cycle;
        fp_n    = fetchpend;
        if (rdy) begin
            if (inject) begin
                inst_n = INT_OPCODE;
                fp_n   = 1'b0;
            end else begin
                if (fetch) begin
                    inst_n = databus;
                    fp_n   = 1'b0;
                end
                cycle_n = cyc_step;
                if (rcyc)
                    fp_n = 1'b1;
                // Trap overrides the (absent) strobe; NOP cycle 1 then
                // advances PC and issues rcyc through the decoder.
                if (trap) begin
                    inst_n  = NOP_OPCODE;
                    cycle_n = 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            inst      <= INT_OPCODE;
            cycle     <= 3'd0;
            fetchpend <= 1'b0;
            resreq    <= 1'b1;
            nmireq    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            inst      <= inst_n;
            cycle     <= cycle_n;
            fetchpend <= fp_n;
            resreq    <= resreq & ~clr_res;
            // set wins over a same-edge clear so an NMI edge is never lost
            nmireq    <= nmi_rise | (nmireq & ~clr_nmi);
            illegal   <= trap;
        end
    end

endmodule

// File: tb/tb_itiming.sv
module tb_itiming;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       clr, rdy, irqin, nmiin, irqdis, icyc, scyc, rcyc, sinst;
    logic [7:0] databus;
    logic [7:0] inst;
    logic [2:0] cycle;
    logic       resreq, nmireq, irqreq, illegal;

    int checks = 0;
    int errors = 0;

    itiming #(.SYNC_STAGES(S)) dut (
        .clk(clk), .clr(clr), .rdy(rdy), .databus(databus),
        .irqin(irqin), .nmiin(nmiin), .irqdis(irqdis),
        .icyc(icyc), .scyc(scyc), .rcyc(rcyc), .sinst(sinst),
        .inst(inst), .cycle(cycle), .resreq(resreq), .nmireq(nmireq),
        .irqreq(irqreq), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // drive one edge's inputs, clock it, sample 1 time unit later
    task automatic step(input logic r, input logic i, input logic s, input logic rc,
                        input logic si, input logic [7:0] db);
        rdy = r; icyc = i; scyc = s; rcyc = rc; sinst = si; databus = db;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       r, i, s, rc;
        logic [7:0] db;
        logic [7:0] e_inst;
        logic [2:0] e_cyc;
    } vec_t;

    vec_t tbl[13];

    // reference model state
    logic [7:0] m_inst;
    int         m_cyc;
    logic       m_fp, m_res, m_nmi, m_ill;
    logic       ih[0:2047];
    logic       nh[0:2047];
    int         n;

    function automatic logic hist(input logic h[0:2047], input int idx);
        return (idx >= 0) ? h[idx] : 1'b0;
    endfunction

    initial begin
        tbl[0]  = '{1,0,0,1, 8'h11, 8'h00, 3'd0}; // rcyc: inst held through cycle 0
        tbl[1]  = '{1,1,0,0, 8'h69, 8'h69, 3'd1}; // fetch
        tbl[2]  = '{1,1,0,0, 8'h12, 8'h69, 3'd2};
        tbl[3]  = '{1,0,1,0, 8'h13, 8'h69, 3'd4};
        tbl[4]  = '{0,1,0,0, 8'h14, 8'h69, 3'd4}; // rdy low freezes
        tbl[5]  = '{1,0,1,0, 8'h15, 8'h69, 3'd6};
        tbl[6]  = '{1,0,1,0, 8'h16, 8'h69, 3'd7}; // 6+2 saturates
        tbl[7]  = '{1,1,0,0, 8'h17, 8'h69, 3'd7}; // 7+1 saturates
        tbl[8]  = '{1,1,0,1, 8'h18, 8'h69, 3'd0}; // rcyc beats icyc
        tbl[9]  = '{0,1,0,0, 8'ha5, 8'h69, 3'd0}; // no fetch while frozen
        tbl[10] = '{1,1,0,0, 8'ha5, 8'ha5, 3'd1};
        tbl[11] = '{1,0,0,1, 8'h19, 8'ha5, 3'd0};
        tbl[12] = '{1,0,1,0, 8'h4c, 8'h4c, 3'd2}; // scyc in fetch

        clr = 1; rdy = 0; irqin = 0; nmiin = 0; irqdis = 0;
        icyc = 0; scyc = 0; rcyc = 0; sinst = 0; databus = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst", inst, 8'h00);
        chk("rst_cycle", cycle, 3'd0);
        chk("rst_resreq", resreq, 1'b1);
        chk("rst_nmireq", nmireq, 1'b0);
        chk("rst_irqreq", irqreq, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        @(negedge clk) clr = 0;

        step(1,1,0,0,1,8'h00);
        chk("sinst_resreq", resreq, 1'b0);
        chk("sinst_inst", inst, 8'h00);
        chk("sinst_cycle", cycle, 3'd1);

        for (int k = 0; k < 13; k++) begin
            step(tbl[k].r, tbl[k].i, tbl[k].s, tbl[k].rc, 1'b0, tbl[k].db);
            chk($sformatf("tbl%0d_inst", k), inst, tbl[k].e_inst);
            chk($sformatf("tbl%0d_cycle", k), cycle, tbl[k].e_cyc);
        end

        // asynchronous abort mid-instruction
        #2 clr = 1;
        #1;
        chk("aclr_inst", inst, 8'h00);
        chk("aclr_cycle", cycle, 3'd0);
        chk("aclr_resreq", resreq, 1'b1);
        @(negedge clk) clr = 0;
        step(1,1,0,0,1,8'h00);
        chk("aclr_sinst", resreq, 1'b0);

        // IRQ: two-clock synchroniser latency, then injection on fetch
        irqin = 1;
        step(0,0,0,0,0,8'h00);
        chk("irq_lat1", irqreq, 1'b0);
        step(0,0,0,0,0,8'h00);
        chk("irq_lat2", irqreq, 1'b1);
        step(1,0,0,1,0,8'h00);
        step(1,1,0,0,0,8'h77);
        chk("irq_inj_inst", inst, 8'h00);
        chk("irq_inj_cycle", cycle, 3'd0);
        irqdis = 1;
        #1;
        chk("irq_masked", irqreq, 1'b0);
        step(1,1,0,0,0,8'h00);
        step(1,0,0,1,0,8'h00);
        step(1,1,0,0,0,8'h55);
        chk("irqdis_fetch", inst, 8'h55);
        chk("irqdis_cycle", cycle, 3'd1);
        irqin = 0;
        step(0,0,0,0,0,8'h00);
        step(0,0,0,0,0,8'h00);
        irqdis = 0;

        // NMI rising edge coinciding with sinst resolves to set
        nmiin = 1;
        step(1,1,0,0,0,8'h00);
        chk("nmi_lat1", nmireq, 1'b0);
        step(1,1,0,0,0,8'h00);
        chk("nmi_lat2", nmireq, 1'b0);
        step(1,1,0,0,1,8'h00);
        chk("nmi_set_wins", nmireq, 1'b1);
        step(1,1,0,0,1,8'h00);
        chk("nmi_cleared", nmireq, 1'b0);
        nmiin = 0;

        // unknown opcode with no strobe
        step(1,0,0,1,0,8'h00);
        step(1,1,0,0,0,8'h02);
        chk("trap_pre_inst", inst, 8'h02);
        step(1,0,0,0,0,8'h00);
`ifdef ILLEGAL_TRAP_EN
        chk("trap_inst", inst, 8'hea);
        chk("trap_cycle", cycle, 3'd1);
        chk("trap_illegal", illegal, 1'b1);
        step(1,1,0,0,0,8'h00);
        chk("trap_pulse_end", illegal, 1'b0);
        chk("trap_next_cycle", cycle, 3'd2);
`else
        chk("hang_inst", inst, 8'h02);
        chk("hang_cycle", cycle, 3'd1);
        chk("hang_illegal", illegal, 1'b0);
`endif

        // randomized run against the behavioural model
        @(negedge clk);
        clr = 1; irqin = 0; nmiin = 0;
        #2 clr = 0;
        m_inst = 8'h00; m_cyc = 0; m_fp = 0; m_res = 1; m_nmi = 0; m_ill = 0; n = 0;
        for (int t = 0; t < 600; t++) begin
            logic       r, i, s, rc, si, irq_now, req;
            logic [7:0] db;
            int         ssel;
            r  = ($urandom_range(0, 3) != 0);
            ssel = $urandom_range(0, 9);
            i  = (ssel < 5) || (ssel == 8);
            s  = (ssel == 5) || (ssel == 8);
            rc = (ssel == 6) || (ssel == 8);
            si = ($urandom_range(0, 7) == 0);
            db = 8'($urandom);
            if ($urandom_range(0, 9) == 0) irqin = ~irqin;
            if ($urandom_range(0, 5) == 0) nmiin = ~nmiin;
            if ($urandom_range(0, 7) == 0) irqdis = ~irqdis;
            ih[n] = irqin;
            nh[n] = nmiin;

            irq_now = hist(ih, n - S) & ~irqdis;
            req     = m_res | m_nmi | irq_now;
            m_ill   = 0;
            if (r) begin
                if (m_cyc == 0 && m_fp && req) begin
                    m_inst = 8'h00;
                    m_fp   = 0;
                end else begin
                    if (m_cyc == 0 && m_fp) begin
                        m_inst = db;
                        m_fp   = 0;
                    end
                    if (rc) begin
                        m_cyc = 0;
                        m_fp  = 1;
                    end else if (s) m_cyc = (m_cyc + 2 > 7) ? 7 : m_cyc + 2;
                    else if (i)     m_cyc = (m_cyc + 1 > 7) ? 7 : m_cyc + 1;
`ifdef ILLEGAL_TRAP_EN
                    if (!(i | s | rc)) begin
                        m_inst = 8'hea;
                        m_cyc  = 1;
                        m_ill  = 1;
                    end
`endif
                end
                if (si) begin
                    if (m_res) m_res = 0;
                    else       m_nmi = 0;
                end
            end
            if (hist(nh, n - S) && !hist(nh, n - S - 1)) m_nmi = 1;

            step(r, i, s, rc, si, db);
            n++;
            chk($sformatf("rnd%0d", t),
                {inst, 1'b0, cycle, resreq, nmireq, irqreq, illegal},
                {m_inst, 1'b0, 3'(m_cyc), m_res, m_nmi, hist(ih, n - S) & ~irqdis, m_ill});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end
endmodule
